axi_dma_burst_planner: RTL and testbench
========================================

# axi_dma_burst_planner

Command-to-burst splitter for the next-generation AXI DMA datapath. It accepts one DMA command at a time (source, destination, byte length, beat size, burst type) and emits a stream of burst requests. Each request is legal for both the read side and the write side: at most MAX_BURST_LEN beats, never crossing a BOUNDARY-byte line on either address, and supporting narrow beat sizes and FIXED bursts. It sits between the command interface and the AR/AW issue logic and tags every burst with a wrapping command ID.

## Interface
- ADDR_WD, 32, address width
- DATA_WD, 32, AXI data width; a power of two, 8..1024
- LEN_WD, 32, command byte-length width
- MAX_BURST_LEN, 16, max beats per burst; a power of two, 1..256
- BOUNDARY, 4096, burst must not cross this byte boundary (INCR only)
- ID_WD, 4, command ID width
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command ready
- cmd_src_addr  in  ADDR_WD  source byte address
- cmd_dst_addr  in  ADDR_WD  destination byte address
- cmd_burst  in  2  0=FIXED, 1=INCR, 2/3 illegal
- cmd_len  in  LEN_WD  transfer length in bytes
- cmd_size  in  3  log2(bytes per beat)
- req_valid  out  1  burst request valid
- req_ready  in  1  burst request ready
- req_src_addr / req_dst_addr  out  ADDR_WD  burst start addresses
- req_len  out  8  beats-1 (AXI LEN encoding)
- req_size  out  3  copy of cmd_size
- req_burst  out  2  copy of cmd_burst
- req_last  out  1  final burst of the command
- req_id  out  ID_WD  ID of the owning command
- err_valid  out  1  one-cycle pulse: command rejected
- err_id  out  ID_WD  ID the rejected command would have used

## Operation
- States: IDLE, EMIT. Reset: IDLE, cmd_ready=1, req_valid=0, err_valid=0, next_id=0. All other outputs are 0 at reset.
- IDLE: cmd_ready=1. When cmd_valid & cmd_ready, the command is checked in the same cycle. It is rejected if any of these hold:
  - cmd_len==0
  - cmd_burst>1
  - cmd_size>log2(DATA_WD/8)
  - src, dst or len is not a multiple of B=1<<cmd_size
  - FIXED with MAX beats exceeded is not an error (see below)
- Reject: err_valid=1 and err_id=next_id for the next cycle. State stays IDLE and next_id is unchanged.
- Accept: the cursor is loaded (src, dst, remaining bytes R, size, burst, id=next_id). next_id increments modulo 2^ID_WD and state goes to EMIT.
- EMIT: req_valid=1. Beats this burst N = min(MAX_BURST_LEN, R/B, Ds/B, Dd/B).
  - For INCR, Ds = BOUNDARY - (src mod BOUNDARY); Dd is the same for dst.
  - For FIXED, Ds and Dd are ignored and the cap is min(MAX_BURST_LEN,16).
- Request fields: req_len=N-1, req_last=(N*B==R).
- On req_valid & req_ready: R -= N*B. For INCR, src and dst each advance by N*B; for FIXED they are unchanged. If req_last, go to IDLE.
- All arithmetic is unsigned at full width. Address increment wraps modulo 2^ADDR_WD. The boundary math uses the low log2(BOUNDARY) bits only.
- cmd_ready=0 throughout EMIT; a new command is never overlapped.

## Timing
- Accept at edge T: req_valid=1 from T+1. Reject at edge T: err_valid=1 during T+1 only.
- Throughput: one burst per cycle while req_ready=1. Each following burst's fields are valid in the cycle after the handshake.
- Last-burst handshake at edge T: req_valid=0 and cmd_ready=1 from T+1. Minimum command-to-command spacing is two cycles for a one-burst command.
- req_* are stable while req_valid & !req_ready. req_* are a function of registered cursor state only; there is no combinational path from cmd_* or req_ready.
- rst mid-command: the next cycle is IDLE, req_valid=0, cmd_ready=1, next_id=0. The in-flight command is discarded with no error.

## Test plan
- DATA_WD=32, MAX=16; src=0x0, dst=0x1000, len=64, size=2, INCR -> one req: len=15, last=1, id=0, addrs 0x0/0x1000.
- len=200, size=2, src=0x100, dst=0x300 -> four reqs:
  - req_len 15, 15, 15, 1
  - src 0x100, 0x140, 0x180, 0x1C0
  - last only on the fourth
- src=0xFF8, dst=0x2000, len=64, size=2 -> two reqs:
  - len=1 (src 0xFF8, dst 0x2000)
  - len=13 (src 0x1000, dst 0x2008), last=1
- Narrow and FIXED bursts:
  - size=0, src=0x3, dst=0x11, len=5 -> req_len=4, size=0
  - FIXED src=0x40, len=80, size=2 -> req_len 15 then 3, addresses constant
- Rejects: len=6/size=2, burst=2, len=0, size=3 -> err_valid one cycle each, no req. The next good command gets the unchanged ID.
- Stall and reset:
  - req_ready=0 for 10 cycles mid-command -> fields held stable.
  - 17 accepted commands -> req_id wraps 15->0.
  - rst during EMIT -> req_valid=0 and cmd_ready=1 next cycle.

Source files
------------

// File: rtl/axi_dma_burst_planner.sv
// Splits one DMA command into AXI-legal bursts valid for both the read and write address,
// honouring the beat cap, the address-boundary rule, narrow beats and FIXED bursts.
module axi_dma_burst_planner #(
    parameter int ADDR_WD       = 32,
    parameter int DATA_WD       = 32,
    parameter int LEN_WD        = 32,
    parameter int MAX_BURST_LEN = 16,
    parameter int BOUNDARY      = 4096,
    parameter int ID_WD         = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ADDR_WD-1:0] cmd_src_addr,
    input  logic [ADDR_WD-1:0] cmd_dst_addr,
    input  logic [1:0]         cmd_burst,
    input  logic [LEN_WD-1:0]  cmd_len,
    input  logic [2:0]         cmd_size,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [ADDR_WD-1:0] req_src_addr,
    output logic [ADDR_WD-1:0] req_dst_addr,
    output logic [7:0]         req_len,
    output logic [2:0]         req_size,
    output logic [1:0]         req_burst,
    output logic               req_last,
    output logic [ID_WD-1:0]   req_id,
    output logic               err_valid,
    output logic [ID_WD-1:0]   err_id
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_e;

    localparam logic [1:0] BURST_INCR = 2'd1;
    localparam int MAX_SIZE  = $clog2(DATA_WD / 8);
    localparam int BND_WD    = $clog2(BOUNDARY);
    localparam int FIXED_CAP = (MAX_BURST_LEN < 16) ? MAX_BURST_LEN : 16;
    localparam int CW0       = (LEN_WD > BND_WD + 1) ? LEN_WD : BND_WD + 1;
    // Wide enough for the byte remainder, the boundary room and 256 beats of 128 bytes.
    localparam int CW        = (CW0 > 16) ? CW0 : 16;

    state_e             state_q, state_d;
    logic [ADDR_WD-1:0] src_q, src_d;
    logic [ADDR_WD-1:0] dst_q, dst_d;
    logic [LEN_WD-1:0]  rem_q, rem_d;
    logic [2:0]         size_q, size_d;
    logic [1:0]         burst_q, burst_d;
    logic [ID_WD-1:0]   id_q, id_d;
    logic [ID_WD-1:0]   next_id_q, next_id_d;
    logic               err_valid_q, err_valid_d;
    logic [ID_WD-1:0]   err_id_q, err_id_d;

    logic [CW-1:0]      beats_rem, beats_src, beats_dst, beats_cap, n_beats;
    logic [LEN_WD-1:0]  burst_bytes;
    logic               burst_last;
    logic [ADDR_WD-1:0] addr_mask;
    logic [LEN_WD-1:0]  len_mask;
    logic               cmd_bad;

    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    always_comb begin
        beats_rem = CW'(rem_q) >> size_q;
        beats_src = (CW'(BOUNDARY) - CW'(src_q[BND_WD-1:0])) >> size_q;
        beats_dst = (CW'(BOUNDARY) - CW'(dst_q[BND_WD-1:0])) >> size_q;
        beats_cap = CW'(FIXED_CAP);
        if (burst_q == BURST_INCR) begin
            beats_cap = CW'(MAX_BURST_LEN);
            if (beats_src < beats_cap) beats_cap = beats_src;
            if (beats_dst < beats_cap) beats_cap = beats_dst;
        end
        n_beats     = (beats_rem < beats_cap) ? beats_rem : beats_cap;
        burst_bytes = LEN_WD'(n_beats << size_q);
        burst_last  = (burst_bytes == rem_q);
    end

    always_comb begin
        addr_mask = ~({ADDR_WD{1'b1}} << cmd_size);
        len_mask  = ~({LEN_WD{1'b1}} << cmd_size);
        cmd_bad   = (cmd_len == '0) || (cmd_burst > BURST_INCR) || (cmd_size > 3'(MAX_SIZE)) ||
                    ((cmd_src_addr & addr_mask) != '0) || ((cmd_dst_addr & addr_mask) != '0) ||
                    ((cmd_len & len_mask) != '0);
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        rem_d       = rem_q;
        size_d      = size_q;
        burst_d     = burst_q;
        id_d        = id_q;
        next_id_d   = next_id_q;
        err_valid_d = 1'b0;
        err_id_d    = err_id_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_bad) begin
                        err_valid_d = 1'b1;
                        err_id_d    = next_id_q;
                    end else begin
                        src_d     = cmd_src_addr;
                        dst_d     = cmd_dst_addr;
                        rem_d     = cmd_len;
                        size_d    = cmd_size;
                        burst_d   = cmd_burst;
                        id_d      = next_id_q;
                        next_id_d = next_id_q + 1'b1;
                        state_d   = EMIT;
                    end
                end
            end
            EMIT: begin
                if (req_ready) begin
                    rem_d = rem_q - burst_bytes;
                    if (burst_q == BURST_INCR) begin
                        src_d = src_q + ADDR_WD'(burst_bytes);
                        dst_d = dst_q + ADDR_WD'(burst_bytes);
                    end
                    if (burst_last) state_d = IDLE;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments only; all combinational math lives above.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            id_q        <= '0;
            next_id_q   <= '0;
            err_valid_q <= 1'b0;
            err_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            rem_q       <= rem_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            id_q        <= id_d;
            next_id_q   <= next_id_d;
            err_valid_q <= err_valid_d;
            err_id_q    <= err_id_d;
        end
    end

    // Request fields come from the registered cursor only and read as zero outside EMIT.
    always_comb begin
        cmd_ready    = (state_q == IDLE);
        req_valid    = (state_q == EMIT);
        req_src_addr = req_valid ? src_q : '0;
        req_dst_addr = req_valid ? dst_q : '0;
        req_len      = req_valid ? 8'(n_beats - CW'(1)) : '0;
        req_size     = req_valid ? size_q : '0;
        req_burst    = req_valid ? burst_q : '0;
        req_last     = req_valid & burst_last;
        req_id       = req_valid ? id_q : '0;
        err_valid    = err_valid_q;
        err_id       = err_id_q;
    end

endmodule

// File: tb/tb_axi_dma_burst_planner.sv
// Bench for axi_dma_burst_planner: directed vector table, hand-written stall/wrap/reset
// sequences, and randomized commands checked against an arithmetic burst-plan model.
module tb_axi_dma_burst_planner;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_src_addr, cmd_dst_addr, cmd_len;
    logic [1:0]  cmd_burst;
    logic [2:0]  cmd_size;
    logic        req_valid, req_ready;
    logic [31:0] req_src_addr, req_dst_addr;
    logic [7:0]  req_len;
    logic [2:0]  req_size;
    logic [1:0]  req_burst;
    logic        req_last;
    logic [3:0]  req_id;
    logic        err_valid;
    logic [3:0]  err_id;

    always #5 clk = ~clk;

    axi_dma_burst_planner #(
        .ADDR_WD(32), .DATA_WD(32), .LEN_WD(32), .MAX_BURST_LEN(16), .BOUNDARY(4096), .ID_WD(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr),
        .cmd_burst(cmd_burst), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src_addr(req_src_addr), .req_dst_addr(req_dst_addr),
        .req_len(req_len), .req_size(req_size), .req_burst(req_burst),
        .req_last(req_last), .req_id(req_id),
        .err_valid(err_valid), .err_id(err_id)
    );

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [7:0]  len;
        logic        last;
    } burst_t;

    typedef struct {
        logic [31:0]      src;
        logic [31:0]      dst;
        logic [31:0]      len;
        logic [1:0]       burst;
        logic [2:0]       size;
        int               nreq;
        logic [3:0][7:0]  rlen;
        logic [3:0][31:0] rsrc;
        logic [3:0][31:0] rdst;
    } vec_t;

    burst_t     exp_q[$];
    bit         exp_rej;
    logic [3:0] exp_id;
    int         n_cmp = 0;
    int         n_err = 0;
    vec_t       vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference plan: walk the byte count, taking as many beats as the cap, the remainder
    // and the distance to the next 4 KiB line on either address allow.
    task automatic model_plan(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                              input logic [1:0] burst, input logic [2:0] size);
        longint b, rem, beats, room;
        logic [31:0] s, d;
        b = longint'(1) << size;
        s = src;
        d = dst;
        exp_q.delete();
        exp_rej = (len == 0) || (burst > 1) || (size > 2) || (longint'(src) % b != 0) ||
                  (longint'(dst) % b != 0) || (longint'(len) % b != 0);
        if (exp_rej) return;
        rem = longint'(len);
        while (rem > 0) begin
            beats = rem / b;
            if (beats > 16) beats = 16;
            if (burst == 2'd1) begin
                room = 4096 - (longint'(s) % 4096);
                if (room / b < beats) beats = room / b;
                room = 4096 - (longint'(d) % 4096);
                if (room / b < beats) beats = room / b;
            end
            exp_q.push_back('{s, d, 8'(beats - 1), (beats * b == rem)});
            rem = rem - beats * b;
            if (burst == 2'd1) begin
                s = s + 32'(beats * b);
                d = d + 32'(beats * b);
            end
        end
    endtask

    task automatic load_vec(input vec_t v);
        exp_q.delete();
        exp_rej = (v.nreq == 0);
        for (int k = 0; k < v.nreq; k++)
            exp_q.push_back('{v.rsrc[k], v.rdst[k], v.rlen[k], (k == v.nreq - 1)});
    endtask

    // Issues one command and checks every cycle until it completes, against exp_q / exp_rej.
    task automatic run_cmd(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                           input logic [1:0] burst, input logic [2:0] size,
                           input int stall_pct, input int stall_burst);
        burst_t b;
        int     held;
        bit     rdy;
        @(negedge clk);
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_src_addr = src;
        cmd_dst_addr = dst;
        cmd_len      = len;
        cmd_burst    = burst;
        cmd_size     = size;
        cmd_valid    = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (exp_rej) begin
            check("err_valid_pulse", 64'(err_valid), 64'd1);
            check("err_id", 64'(err_id), 64'(exp_id));
            check("req_valid_on_reject", 64'(req_valid), 64'd0);
            @(negedge clk);
            check("err_valid_clear", 64'(err_valid), 64'd0);
            check("req_valid_after_reject", 64'(req_valid), 64'd0);
            return;
        end
        check("err_valid_on_accept", 64'(err_valid), 64'd0);
        for (int i = 0; i < exp_q.size(); i++) begin
            b    = exp_q[i];
            held = 0;
            while (1) begin
                check("req_valid", 64'(req_valid), 64'd1);
                check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
                check("req_src_addr", 64'(req_src_addr), 64'(b.src));
                check("req_dst_addr", 64'(req_dst_addr), 64'(b.dst));
                check("req_len", 64'(req_len), 64'(b.len));
                check("req_last", 64'(req_last), 64'(b.last));
                check("req_size", 64'(req_size), 64'(size));
                check("req_burst", 64'(req_burst), 64'(burst));
                check("req_id", 64'(req_id), 64'(exp_id));
                if (i == stall_burst && held < 10) rdy = 1'b0;
                else if (held < 20 && $urandom_range(0, 99) < stall_pct) rdy = 1'b0;
                else rdy = 1'b1;
                req_ready = rdy;
                @(negedge clk);
                if (rdy) break;
                held++;
            end
        end
        req_ready = 1'b0;
        check("req_valid_done", 64'(req_valid), 64'd0);
        check("cmd_ready_done", 64'(cmd_ready), 64'd1);
        exp_id = exp_id + 4'd1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s, d, l;
        logic [1:0]  bt;
        logic [2:0]  sz;
        int          bb;

        vecs[0] = '{32'h0, 32'h1000, 32'd64, 2'd1, 3'd2, 1,
                    {24'h0, 8'd15}, {96'h0, 32'h0}, {96'h0, 32'h1000}};
        vecs[1] = '{32'h100, 32'h300, 32'd200, 2'd1, 3'd2, 4,
                    {8'd1, 8'd15, 8'd15, 8'd15},
                    {32'h1C0, 32'h180, 32'h140, 32'h100}, {32'h3C0, 32'h380, 32'h340, 32'h300}};
        vecs[2] = '{32'hFF8, 32'h2000, 32'd64, 2'd1, 3'd2, 2,
                    {16'h0, 8'd13, 8'd1}, {64'h0, 32'h1000, 32'hFF8}, {64'h0, 32'h2008, 32'h2000}};
        vecs[3] = '{32'h3, 32'h11, 32'd5, 2'd1, 3'd0, 1,
                    {24'h0, 8'd4}, {96'h0, 32'h3}, {96'h0, 32'h11}};
        vecs[4] = '{32'h40, 32'h80, 32'd80, 2'd0, 3'd2, 2,
                    {16'h0, 8'd3, 8'd15}, {64'h0, 32'h40, 32'h40}, {64'h0, 32'h80, 32'h80}};
        vecs[5] = '{32'h0, 32'h0, 32'd6, 2'd1, 3'd2, 0, '0, '0, '0};
        vecs[6] = '{32'h0, 32'h0, 32'd16, 2'd2, 3'd2, 0, '0, '0, '0};
        vecs[7] = '{32'h0, 32'h0, 32'd0, 2'd1, 3'd2, 0, '0, '0, '0};
        vecs[8] = '{32'h0, 32'h0, 32'd16, 2'd1, 3'd3, 0, '0, '0, '0};
        vecs[9] = '{32'h20, 32'h40, 32'd16, 2'd1, 3'd2, 1,
                    {24'h0, 8'd3}, {96'h0, 32'h20}, {96'h0, 32'h40}};

        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_src_addr = '0;
        cmd_dst_addr = '0;
        cmd_len      = '0;
        cmd_burst    = '0;
        cmd_size     = '0;
        req_ready    = 1'b0;
        exp_id       = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        check("reset_req_valid", 64'(req_valid), 64'd0);
        check("reset_err_valid", 64'(err_valid), 64'd0);
        check("reset_err_id", 64'(err_id), 64'd0);
        check("reset_req_len", 64'(req_len), 64'd0);
        check("reset_req_last", 64'(req_last), 64'd0);

        // Directed table; the four-burst command is held off for 10 cycles on its second burst.
        for (int v = 0; v < 10; v++) begin
            load_vec(vecs[v]);
            run_cmd(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].burst, vecs[v].size,
                    0, (v == 1) ? 1 : -1);
        end

        // Reset while a multi-burst command is being emitted.
        @(negedge clk);
        cmd_src_addr = 32'h100;
        cmd_dst_addr = 32'h300;
        cmd_len      = 32'd200;
        cmd_burst    = 2'd1;
        cmd_size     = 3'd2;
        cmd_valid    = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("pre_reset_req_valid", 64'(req_valid), 64'd1);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_req_valid", 64'(req_valid), 64'd0);
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("midrst_err_valid", 64'(err_valid), 64'd0);
        exp_id = '0;

        // Seventeen accepted commands: the ID walks 0..15 and wraps back to 0.
        for (int k = 0; k < 17; k++) begin
            model_plan(32'h1000 * k, 32'h8000, 32'd8, 2'd1, 3'd2);
            run_cmd(32'h1000 * k, 32'h8000, 32'd8, 2'd1, 3'd2, 0, -1);
        end

        for (int r = 0; r < 150; r++) begin
            sz = 3'($urandom_range(0, 3));
            bb = 1 << sz;
            s  = $urandom;
            d  = $urandom;
            if ($urandom_range(0, 1) == 1) s[11:0] = 12'(4096 - $urandom_range(1, 256));
            if ($urandom_range(0, 1) == 1) d[11:0] = 12'(4096 - $urandom_range(1, 256));
            if ($urandom_range(0, 19) == 0) s[31:12] = 20'hFFFFF;
            if ($urandom_range(0, 9) != 0) s = s & ~32'(bb - 1);
            if ($urandom_range(0, 9) != 0) d = d & ~32'(bb - 1);
            l = 32'(bb) * $urandom_range(0, (sz == 0) ? 400 : 200);
            if ($urandom_range(0, 19) == 0) l = l + 32'd1;
            if ($urandom_range(0, 15) == 0) bt = 2'($urandom_range(2, 3));
            else bt = ($urandom_range(0, 3) == 0) ? 2'd0 : 2'd1;
            model_plan(s, d, l, bt, sz);
            run_cmd(s, d, l, bt, sz, 25, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
